// File: rtl/alu_arb_pkg.sv
// Shared definitions for the alu_arb slice: ALU width, opcodes and FSM states.
package alu_arb_pkg;

   localparam int ALU_W = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_LSL = 3'b110;
   localparam logic [2:0] OP_LSR = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } alu_arb_state_t;

endpackage

// File: rtl/alu_arb_rr_arb.sv
// Combinational round-robin arbiter: first set request at or above ptr,
// wrapping past NREQ-1 back to 0. Returns one-hot and binary forms.
module rr_arb #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   logic [IW-1:0] cand;

   // Scan upward from ptr; the first hit wins and masks later candidates.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IW'((int'(ptr) + k) % NREQ);
         if (!any && req[cand]) begin
            any       = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_conv.sv
// Shared 8-bit ALU with a two-way A-operand mux. Arithmetic wraps modulo 256,
// shifts move by one bit and fill with zero.
module alu_conv
   import alu_arb_pkg::*;
(
   input  logic [ALU_W-1:0] a0_mux,
   input  logic [ALU_W-1:0] a1_mux,
   input  logic             a_sel,
   input  logic [ALU_W-1:0] b,
   input  logic [2:0]       ctrl,
   output logic [ALU_W-1:0] y
);

   logic [ALU_W-1:0] a;

   // Select operand A, then evaluate the requested operation.
   always_comb begin
      a = a_sel ? a1_mux : a0_mux;
      y = '0;
      case (ctrl)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_OR:   y = a | b;
         OP_AND:  y = a & b;
         OP_XOR:  y = a ^ b;
         OP_NOT:  y = ~a;
         OP_LSL:  y = {a[ALU_W-2:0], 1'b0};
         OP_LSR:  y = {1'b0, a[ALU_W-1:1]};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_arb.sv
// Round-robin sequencer sharing one alu_conv among NREQ requesters.
// One operation in flight: IDLE grants and captures operands, EXEC computes,
// RESP holds the result until the owning requester accepts it.
// Define ALU_ARB_ACC_EN to build per-requester accumulators selectable as
// operand A via req_acc; without it req_acc is ignored.
module alu_arb
   import alu_arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*ALU_W-1:0] req_a,
   input  logic [NREQ*ALU_W-1:0] req_b,
   input  logic [NREQ*3-1:0]     req_op,
   input  logic [NREQ-1:0]       req_acc,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [ALU_W-1:0]      rsp_data,
   output logic                  busy
);

   localparam int IW = $clog2(NREQ);
   localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

   alu_arb_state_t   state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    g_r;
   logic [ALU_W-1:0] a0_r;
   logic [ALU_W-1:0] b_r;
   logic [2:0]       op_r;
   logic [ALU_W-1:0] res_r;
   logic [NREQ-1:0]  rsp_valid_r;
   logic             busy_r;

   logic [NREQ-1:0]  gnt;
   logic [IW-1:0]    gnt_idx;
   logic             gnt_any;

   logic             a_sel;
   logic [ALU_W-1:0] a1_mux;
   logic [ALU_W-1:0] alu_y;

   rr_arb #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_arb (
      .req (req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

`ifdef ALU_ARB_ACC_EN
   logic             acc_sel_r;
   logic [ALU_W-1:0] acc [NREQ];

   assign a_sel  = acc_sel_r;
   assign a1_mux = acc[g_r];
`else
   logic unused_req_acc;

   assign a_sel          = 1'b0;
   assign a1_mux         = '0;
   assign unused_req_acc = ^req_acc;
`endif

   alu_conv u_alu (
      .a0_mux (a0_r),
      .a1_mux (a1_mux),
      .a_sel  (a_sel),
      .b      (b_r),
      .ctrl   (op_r),
      .y      (alu_y)
   );

   // Grant is offered only while idle and out of reset; the handshake path is
   // deliberately combinational from req_valid.
   assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = res_r;
   assign busy      = busy_r;

   // Sequencer FSM: grant/capture, execute, then hold the response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         g_r         <= '0;
         a0_r        <= '0;
         b_r         <= '0;
         op_r        <= OP_ADD;
         res_r       <= '0;
         rsp_valid_r <= '0;
         busy_r      <= 1'b0;
`ifdef ALU_ARB_ACC_EN
         acc_sel_r   <= 1'b0;
         for (int i = 0; i < NREQ; i++) acc[i] <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  a0_r      <= req_a[gnt_idx*ALU_W +: ALU_W];
                  b_r       <= req_b[gnt_idx*ALU_W +: ALU_W];
                  op_r      <= req_op[gnt_idx*3 +: 3];
                  g_r       <= gnt_idx;
`ifdef ALU_ARB_ACC_EN
                  acc_sel_r <= req_acc[gnt_idx];
`endif
                  busy_r    <= 1'b1;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               res_r       <= alu_y;
`ifdef ALU_ARB_ACC_EN
               acc[g_r]    <= alu_y;
`endif
               rsp_valid_r <= GNT_ONE << g_r;
               state       <= RESP;
            end
            RESP: begin
               if (rsp_ready[g_r]) begin
                  ptr         <= (g_r == IW'(NREQ - 1)) ? '0 : g_r + 1'b1;
                  rsp_valid_r <= '0;
                  busy_r      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arb.sv
// Directed testbench for alu_arb (NREQ = 4); covers the accumulator feature
// when ALU_ARB_ACC_EN is defined, and its absence otherwise.
module tb_alu_arb;
   import alu_arb_pkg::*;

   localparam int NREQ = 4;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*8-1:0]     req_a;
   logic [NREQ*8-1:0]     req_b;
   logic [NREQ*3-1:0]     req_op;
   logic [NREQ-1:0]       req_acc;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [7:0]            rsp_data;
   logic                  busy;

   int n_checks = 0;
   int n_fail   = 0;

   alu_arb #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .req_acc   (req_acc),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one request from requester i and record what the DUT shows at
   // grant, in EXEC and in RESP. rsp_ready is all ones so RESP lasts one cycle.
   task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic acc,
                         output logic [NREQ-1:0] gnt_o, output logic exec_busy_o,
                         output logic [NREQ-1:0] exec_vld_o,
                         output logic [NREQ-1:0] vld_o, output logic [7:0] data_o);
      @(negedge clk);
      req_valid          = '0;
      req_valid[i]       = 1'b1;
      req_a[i*8 +: 8]    = a;
      req_b[i*8 +: 8]    = b;
      req_op[i*3 +: 3]   = op;
      req_acc[i]         = acc;
      rsp_ready          = '1;
      #1 gnt_o = req_ready;
      @(posedge clk); #1;
      req_valid   = '0;
      req_acc     = '0;
      exec_busy_o = busy;
      exec_vld_o  = rsp_valid;
      @(posedge clk); #1;
      vld_o  = rsp_valid;
      data_o = rsp_data;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      req_acc   = '0;
      rsp_ready = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '1;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      req_acc   = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b want %b", req_ready, 4'b0000); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0000", rsp_valid); end
      n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
      req_valid = '0;
      rst_n     = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_add_sub();
      logic [NREQ-1:0] g, ev, v;
      logic            eb;
      logic [7:0]      d;
      run_op(0, 8'h0F, 8'h01, OP_ADD, 1'b0, g, eb, ev, v, d);
      n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL add_grant: got %b want 0001", g); end
      n_checks++; if (eb !== 1'b1) begin n_fail++; $display("FAIL add_exec_busy: got %b want 1", eb); end
      n_checks++; if (ev !== 4'b0000) begin n_fail++; $display("FAIL add_exec_rsp_valid: got %b want 0000", ev); end
      n_checks++; if (v !== 4'b0001) begin n_fail++; $display("FAIL add_rsp_valid: got %b want 0001", v); end
      n_checks++; if (d !== 8'h10) begin n_fail++; $display("FAIL add_data: got %h want 10", d); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_back_idle: busy %b want 0", busy); end
      run_op(0, 8'h00, 8'h01, OP_SUB, 1'b0, g, eb, ev, v, d);
      n_checks++; if (v !== 4'b0001) begin n_fail++; $display("FAIL sub_rsp_valid: got %b want 0001", v); end
      n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL sub_data: got %h want ff", d); end
   endtask

   task automatic test_ops();
      logic [7:0] ta [6] = '{8'h81, 8'h81, 8'h5A, 8'hF0, 8'hF0, 8'hFF};
      logic [7:0] tb [6] = '{8'h00, 8'h00, 8'hFF, 8'h0C, 8'h3C, 8'h0F};
      logic [2:0] to [6] = '{OP_LSR, OP_LSL, OP_NOT, OP_OR, OP_AND, OP_XOR};
      logic [7:0] te [6] = '{8'h40, 8'h02, 8'hA5, 8'hFC, 8'h30, 8'hF0};
      logic [NREQ-1:0] g, ev, v;
      logic            eb;
      logic [7:0]      d;
      for (int k = 0; k < 6; k++) begin
         run_op(3, ta[k], tb[k], to[k], 1'b0, g, eb, ev, v, d);
         n_checks++; if (v !== 4'b1000) begin n_fail++; $display("FAIL ops_rsp_valid[%0d]: got %b want 1000", k, v); end
         n_checks++; if (d !== te[k]) begin n_fail++; $display("FAIL ops_data[%0d]: got %h want %h", k, d, te[k]); end
      end
   endtask

   task automatic test_fairness();
      int          order [5] = '{0, 1, 2, 3, 0};
      logic [NREQ-1:0] exp_oh;
      logic [7:0]  exp_d;
      do_reset();
      @(negedge clk);
      req_a     = {8'h30, 8'h20, 8'h10, 8'h00};
      req_b     = {4{8'h01}};
      req_op    = {4{OP_ADD}};
      req_acc   = '0;
      rsp_ready = '1;
      req_valid = '1;
      #1;
      for (int k = 0; k < 5; k++) begin
         exp_oh = 4'b0001 << order[k];
         exp_d  = 8'(order[k] * 16 + 1);
         n_checks++; if (req_ready !== exp_oh) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b want %b", k, req_ready, exp_oh); end
         @(posedge clk); #1;
         @(posedge clk); #1;
         n_checks++; if (rsp_valid !== exp_oh) begin n_fail++; $display("FAIL fair_rsp_valid[%0d]: got %b want %b", k, rsp_valid, exp_oh); end
         n_checks++; if (rsp_data !== exp_d) begin n_fail++; $display("FAIL fair_data[%0d]: got %h want %h", k, rsp_data, exp_d); end
         @(posedge clk); #1;
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure();
      do_reset();
      @(negedge clk);
      req_a[8 +: 8]  = 8'h20; req_b[8 +: 8]  = 8'h22; req_op[3 +: 3] = OP_ADD;
      req_a[16 +: 8] = 8'hAA; req_b[16 +: 8] = 8'h55; req_op[6 +: 3] = OP_XOR;
      req_acc   = '0;
      rsp_ready = 4'b1101;
      req_valid = 4'b0110;
      #1;
      n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b0100;
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_rsp_valid[%0d]: got %b want 0010", k, rsp_valid); end
         n_checks++; if (rsp_data !== 8'h42) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want 42", k, rsp_data); end
         n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b want 0000", k, req_ready); end
         n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d]: got %b want 1", k, busy); end
         @(posedge clk); #1;
      end
      rsp_ready = 4'b1111;
      @(posedge clk); #1;
      n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant2: got %b want 0100", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL bp_rsp_valid2: got %b want 0100", rsp_valid); end
      n_checks++; if (rsp_data !== 8'hFF) begin n_fail++; $display("FAIL bp_data2: got %h want ff", rsp_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_accumulate();
      logic [NREQ-1:0] g, ev, v;
      logic            eb;
      logic [7:0]      d;
      do_reset();
`ifdef ALU_ARB_ACC_EN
      run_op(2, 8'h10, 8'h00, OP_ADD, 1'b0, g, eb, ev, v, d);
      n_checks++; if (d !== 8'h10) begin n_fail++; $display("FAIL acc_seed: got %h want 10", d); end
      run_op(2, 8'h99, 8'h05, OP_ADD, 1'b1, g, eb, ev, v, d);
      n_checks++; if (d !== 8'h15) begin n_fail++; $display("FAIL acc_chain: got %h want 15", d); end
      run_op(1, 8'h77, 8'h01, OP_ADD, 1'b1, g, eb, ev, v, d);
      n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL acc_separate: got %h want 01", d); end
      n_checks++; if (v !== 4'b0010) begin n_fail++; $display("FAIL acc_rsp_valid: got %b want 0010", v); end
`else
      run_op(2, 8'h10, 8'h05, OP_ADD, 1'b1, g, eb, ev, v, d);
      n_checks++; if (d !== 8'h15) begin n_fail++; $display("FAIL noacc_a_used: got %h want 15", d); end
      run_op(1, 8'h77, 8'h01, OP_ADD, 1'b1, g, eb, ev, v, d);
      n_checks++; if (d !== 8'h78) begin n_fail++; $display("FAIL noacc_a_used2: got %h want 78", d); end
      n_checks++; if (v !== 4'b0010) begin n_fail++; $display("FAIL noacc_rsp_valid: got %b want 0010", v); end
`endif
   endtask

   task automatic test_reset_mid();
      logic [NREQ-1:0] g, ev, v;
      logic            eb;
      logic [7:0]      d;
      run_op(2, 8'h30, 8'h00, OP_ADD, 1'b0, g, eb, ev, v, d);
      n_checks++; if (d !== 8'h30) begin n_fail++; $display("FAIL rmid_setup: got %h want 30", d); end
      @(negedge clk);
      req_valid       = 4'b1000;
      req_a[24 +: 8]  = 8'h40;
      req_b[24 +: 8]  = 8'h01;
      req_op[9 +: 3]  = OP_ADD;
      rsp_ready       = '1;
      #1;
      n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rmid_grant: got %b want 1000", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_exec_busy: got %b want 1", busy); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rmid_rsp_valid: got %b want 0000", rsp_valid); end
      n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rmid_rsp_data: got %h want 00", rsp_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
      @(negedge clk);
      req_valid = '1;
      #1;
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr: got %b want 0001", req_ready); end
      req_valid = '0;
      run_op(2, 8'h00, 8'h07, OP_ADD, 1'b1, g, eb, ev, v, d);
      n_checks++; if (d !== 8'h07) begin n_fail++; $display("FAIL rmid_acc_cleared: got %h want 07", d); end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_ops();
      test_fairness();
      test_backpressure();
      test_accumulate();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
